// File: rtl/dma_job_scheduler.sv
// Job queue and sequencer for loopback DMA transfers: each queued job issues its
// S2MM and MM2S descriptors, waits for both completion statuses, then retires.
module dma_job_scheduler #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_LEN_WIDTH  = 32,
  parameter int AXI_TAG_WIDTH  = 8,
  parameter int DEPTH          = 4
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic                                    job_valid,
  output logic                                    job_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]               job_src_addr,
  input  logic [AXI_ADDR_WIDTH-1:0]               job_dst_addr,
  input  logic [AXI_LEN_WIDTH-1:0]                job_bytes,
  input  logic                                    clear_err,
  input  logic                                    flush,
  output logic [AXI_ADDR_WIDTH+AXI_LEN_WIDTH-1:0] mm2s_desc,
  output logic                                    mm2s_valid,
  input  logic                                    mm2s_ready,
  input  logic                                    mm2s_status_valid,
  input  logic [3:0]                              mm2s_status_error,
  output logic [AXI_ADDR_WIDTH+AXI_LEN_WIDTH-1:0] s2mm_desc,
  output logic [AXI_TAG_WIDTH-1:0]                s2mm_tag,
  output logic                                    s2mm_valid,
  input  logic                                    s2mm_ready,
  input  logic                                    s2mm_status_valid,
  input  logic [3:0]                              s2mm_status_error,
  output logic                                    busy,
  output logic [$clog2(DEPTH):0]                  queue_count,
  output logic [15:0]                             jobs_done,
  output logic                                    err,
  output logic [7:0]                              err_code,
  output logic                                    irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RETIRE,
    S_HALT
  } state_e;

  state_e state_q, state_d;

  logic [AXI_ADDR_WIDTH-1:0] src_mem [DEPTH];
  logic [AXI_ADDR_WIDTH-1:0] dst_mem [DEPTH];
  logic [AXI_LEN_WIDTH-1:0]  len_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic mm2s_acc_q, mm2s_acc_d, s2mm_acc_q, s2mm_acc_d;
  logic mm2s_done_q, mm2s_done_d, s2mm_done_q, s2mm_done_d;
  logic [3:0] mm2s_stat_q, mm2s_stat_d, s2mm_stat_q, s2mm_stat_d;

  logic                     err_q, err_d;
  logic [7:0]               err_code_q, err_code_d;
  logic                     irq_q, irq_d;
  logic [15:0]              jobs_done_q, jobs_done_d;
  logic [AXI_TAG_WIDTH-1:0] seq_q, seq_d;

  logic push, pop, head_zero, in_flight, tracking;
  logic mm2s_fire, s2mm_fire, mm2s_cap, s2mm_cap, err_set;

  assign job_ready   = (count_q < CNT_W'(DEPTH));
  assign push        = job_valid && job_ready && !flush;
  assign head_zero   = (len_mem[rd_ptr_q] == '0);

  assign mm2s_valid  = (state_q == S_ISSUE) && !mm2s_acc_q && !head_zero;
  assign s2mm_valid  = (state_q == S_ISSUE) && !s2mm_acc_q && !head_zero;
  assign mm2s_fire   = mm2s_valid && mm2s_ready;
  assign s2mm_fire   = s2mm_valid && s2mm_ready;
  assign mm2s_desc   = mm2s_valid ? {len_mem[rd_ptr_q], src_mem[rd_ptr_q]} : '0;
  assign s2mm_desc   = s2mm_valid ? {len_mem[rd_ptr_q], dst_mem[rd_ptr_q]} : '0;
  assign s2mm_tag    = s2mm_valid ? seq_q : '0;

  // A status only counts once its own descriptor was accepted in an earlier cycle.
  assign mm2s_cap    = mm2s_acc_q && !mm2s_done_q && mm2s_status_valid;
  assign s2mm_cap    = s2mm_acc_q && !s2mm_done_q && s2mm_status_valid;
  assign err_set     = (mm2s_cap && (mm2s_status_error != 4'h0)) ||
                       (s2mm_cap && (s2mm_status_error != 4'h0));

  assign in_flight   = (state_q == S_WAIT) || (state_q == S_RETIRE) ||
                       ((state_q == S_ISSUE) &&
                        (mm2s_acc_q || s2mm_acc_q || mm2s_fire || s2mm_fire));
  assign pop         = (state_q == S_RETIRE) ||
                       ((state_q == S_HALT) && clear_err && (count_q != '0));
  assign tracking    = (state_q == S_ISSUE) || (state_q == S_WAIT);

  assign busy        = (state_q != S_IDLE) || (count_q != '0);
  assign queue_count = count_q;
  assign jobs_done   = jobs_done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign irq         = irq_q;

  // NOTE: queue storage has no reset; count and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      src_mem[wr_ptr_q] <= job_src_addr;
      dst_mem[wr_ptr_q] <= job_dst_addr;
      len_mem[wr_ptr_q] <= job_bytes;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (flush) begin
      if (in_flight) begin
        wr_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d  = pop ? '0 : CNT_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = rd_ptr_q;
        count_d  = '0;
      end
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (count_d != '0) state_d = S_ISSUE;
      S_ISSUE: begin
        if (flush && !in_flight)                 state_d = S_IDLE;
        else if (head_zero)                      state_d = S_RETIRE;
        else if ((mm2s_acc_q || mm2s_fire) &&
                 (s2mm_acc_q || s2mm_fire))      state_d = S_WAIT;
      end
      S_WAIT:   if (mm2s_done_q && s2mm_done_q) state_d = err_q ? S_HALT : S_RETIRE;
      S_RETIRE: state_d = (count_d != '0) ? S_ISSUE : S_IDLE;
      S_HALT:   if (clear_err) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mm2s_acc_d  = 1'b0;
    s2mm_acc_d  = 1'b0;
    mm2s_done_d = 1'b0;
    s2mm_done_d = 1'b0;
    mm2s_stat_d = 4'h0;
    s2mm_stat_d = 4'h0;
    if (tracking) begin
      mm2s_acc_d  = mm2s_acc_q  || mm2s_fire;
      s2mm_acc_d  = s2mm_acc_q  || s2mm_fire;
      mm2s_done_d = mm2s_done_q || mm2s_cap;
      s2mm_done_d = s2mm_done_q || s2mm_cap;
      mm2s_stat_d = mm2s_cap ? mm2s_status_error : mm2s_stat_q;
      s2mm_stat_d = s2mm_cap ? s2mm_status_error : s2mm_stat_q;
    end

    err_d      = err_q;
    err_code_d = err_code_q;
    if (err_set) begin
      err_d      = 1'b1;
      err_code_d = {s2mm_stat_d, mm2s_stat_d};
    end
    if ((state_q == S_HALT) && clear_err) begin
      err_d      = 1'b0;
      err_code_d = 8'h00;
    end

    irq_d       = (state_d == S_RETIRE) || (err_set && !err_q);
    jobs_done_d = jobs_done_q + 16'((state_q == S_RETIRE) ? 1 : 0);
    seq_d       = seq_q + AXI_TAG_WIDTH'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      mm2s_acc_q  <= 1'b0;
      s2mm_acc_q  <= 1'b0;
      mm2s_done_q <= 1'b0;
      s2mm_done_q <= 1'b0;
      mm2s_stat_q <= 4'h0;
      s2mm_stat_q <= 4'h0;
      err_q       <= 1'b0;
      err_code_q  <= 8'h00;
      irq_q       <= 1'b0;
      jobs_done_q <= 16'h0000;
      seq_q       <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      mm2s_acc_q  <= mm2s_acc_d;
      s2mm_acc_q  <= s2mm_acc_d;
      mm2s_done_q <= mm2s_done_d;
      s2mm_done_q <= s2mm_done_d;
      mm2s_stat_q <= mm2s_stat_d;
      s2mm_stat_q <= s2mm_stat_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      irq_q       <= irq_d;
      jobs_done_q <= jobs_done_d;
      seq_q       <= seq_d;
    end
  end

endmodule
